led_stepper_db: RTL and testbench

- Parametrised successor to the single-button LED rotator.
- Two debounced push-buttons (left/right) step a WIDTH-bit LED pattern, with two selectable modes (rotate / bar-graph) and optional hold-to-repeat.
- Debouncing is built in: per-channel synchroniser + counter filter.
- Sits between the board buttons and the LED bank; also exports a step counter for the board display.

---
 rtl/led_stepper_pkg.sv | 15 +
 rtl/led_stepper_db_chan.sv | 109 ++++++++++
 rtl/led_stepper_db.sv | 82 ++++++++
 tb/tb_led_stepper_db.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_stepper_pkg.sv
// Shared constants and types for the debounced two-button LED stepper.
package led_stepper_pkg;

  // MODE input encoding.
  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_BAR    = 1'b1;

  // Resolved step direction for one clock cycle.
  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

endpackage

// File: rtl/led_stepper_db_chan.sv
// One button channel: two-flop synchroniser, counter-based debounce filter,
// rising-edge press tick and optional hold-to-repeat tick generator.
module db_chan #(
  parameter int unsigned DB_CYCLES     = 2_000_000,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic CLK_100M,
  input  logic RST_N,
  input  logic raw,
  output logic level,
  output logic tick
);

  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            raw_s;
  logic            db_q, db_d;
  logic            db_dly_q;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            press_tick;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) sync_q <= '0;
    else        sync_q <= {sync_q[0], raw};
  end

  assign raw_s = sync_q[1];

  // Debounce: count consecutive cycles disagreeing with the accepted level.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (raw_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      db_d  = ~db_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  // Debounce state plus a delayed copy of the level for edge detection.
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      db_q     <= 1'b0;
      cnt_q    <= '0;
      db_dly_q <= 1'b0;
    end else begin
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      db_dly_q <= db_q;
    end
  end

  assign level      = db_q;
  assign press_tick = db_q & ~db_dly_q;

  generate
    if (REPEAT_EN) begin : g_rep
      localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

      logic [RP_W-1:0] rcnt_q, rcnt_d;
      logic            phase_q, phase_d;
      logic            rep_tick;

      // Repeat timer: counts cycles since the last tick while the level is
      // held; phase 0 waits the initial delay, phase 1 the repeat period.
      always_comb begin
        rcnt_d   = rcnt_q;
        phase_d  = phase_q;
        rep_tick = 1'b0;
        if (!db_q) begin
          rcnt_d  = '0;
          phase_d = 1'b0;
        end else if ((!phase_q && rcnt_q == RP_W'(REPEAT_DELAY)) ||
                     ( phase_q && rcnt_q == RP_W'(REPEAT_PERIOD))) begin
          rep_tick = 1'b1;
          rcnt_d   = RP_W'(1);
          phase_d  = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RP_W'(1);
        end
      end

      // Repeat timer registers.
      always_ff @(posedge CLK_100M or negedge RST_N) begin
        if (!RST_N) begin
          rcnt_q  <= '0;
          phase_q <= 1'b0;
        end else begin
          rcnt_q  <= rcnt_d;
          phase_q <= phase_d;
        end
      end

      assign tick = press_tick | rep_tick;
    end else begin : g_norep
      assign tick = press_tick;
    end
  endgenerate

endmodule

// File: rtl/led_stepper_db.sv
// Two debounced buttons step a WIDTH-bit LED pattern in rotate or bar-graph
// mode; STEP_CNT counts pattern changes that actually took effect.
module led_stepper_db
  import led_stepper_pkg::*;
#(
  parameter int unsigned       WIDTH         = 8,
  parameter logic [WIDTH-1:0]  INIT_PATTERN  = WIDTH'(8'h01),
  parameter int unsigned       DB_CYCLES     = 2_000_000,
  parameter bit                REPEAT_EN     = 1'b1,
  parameter int unsigned       REPEAT_DELAY  = 50_000_000,
  parameter int unsigned       REPEAT_PERIOD = 10_000_000,
  parameter int unsigned       CNT_W         = 16
) (
  input  logic             CLK_100M,
  input  logic             RST_N,
  input  logic             BTN_LEFT,
  input  logic             BTN_RIGHT,
  input  logic             MODE,
  output logic [WIDTH-1:0] LED,
  output logic [CNT_W-1:0] STEP_CNT,
  output logic             BUSY
);

  logic             level_l, level_r;
  logic             tick_l, tick_r;
  dir_e             dir;
  logic [WIDTH-1:0] led_q, led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  db_chan #(
    .DB_CYCLES(DB_CYCLES), .REPEAT_EN(REPEAT_EN),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_left (
    .CLK_100M(CLK_100M), .RST_N(RST_N), .raw(BTN_LEFT),
    .level(level_l), .tick(tick_l)
  );

  db_chan #(
    .DB_CYCLES(DB_CYCLES), .REPEAT_EN(REPEAT_EN),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_right (
    .CLK_100M(CLK_100M), .RST_N(RST_N), .raw(BTN_RIGHT),
    .level(level_r), .tick(tick_r)
  );

  // Direction decode: simultaneous left and right ticks cancel out.
  always_comb begin
    dir = DIR_NONE;
    if (tick_l && !tick_r)      dir = DIR_LEFT;
    else if (tick_r && !tick_l) dir = DIR_RIGHT;
  end

  // Next pattern and step count; bar-graph saturation falls out naturally
  // because a saturated shift leaves the pattern equal to itself.
  always_comb begin
    led_d = led_q;
    case (dir)
      DIR_LEFT:  led_d = (MODE == MODE_BAR) ? {led_q[WIDTH-2:0], 1'b1}
                                            : {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      DIR_RIGHT: led_d = (MODE == MODE_BAR) ? {1'b0, led_q[WIDTH-1:1]}
                                            : {led_q[0], led_q[WIDTH-1:1]};
      default:   led_d = led_q;
    endcase
    cnt_d = (led_d != led_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Pattern and step counter registers.
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      led_q <= INIT_PATTERN;
      cnt_q <= '0;
    end else begin
      led_q <= led_d;
      cnt_q <= cnt_d;
    end
  end

  assign LED      = led_q;
  assign STEP_CNT = cnt_q;
  assign BUSY     = level_l | level_r;

endmodule

// File: tb/tb_led_stepper_db.sv
// Self-checking bench for led_stepper_db with a behavioural reference model.
module tb_led_stepper_db;

  localparam int W  = 8;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int CW = 16;

  logic          CLK_100M = 1'b0;
  logic          RST_N;
  logic          BTN_LEFT;
  logic          BTN_RIGHT;
  logic          MODE;
  logic [W-1:0]  LED;
  logic [CW-1:0] STEP_CNT;
  logic          BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0]  m_led;
  logic [CW-1:0] m_cnt;
  logic          m_db[2];
  int            m_age[2];
  logic [DB+1:0] m_hist[2];
  logic [W-1:0]  exp_q[$];

  led_stepper_db #(
    .WIDTH(W), .INIT_PATTERN(8'h01), .DB_CYCLES(DB), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(CW)
  ) dut (
    .CLK_100M(CLK_100M), .RST_N(RST_N), .BTN_LEFT(BTN_LEFT),
    .BTN_RIGHT(BTN_RIGHT), .MODE(MODE), .LED(LED),
    .STEP_CNT(STEP_CNT), .BUSY(BUSY)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK_100M = ~CLK_100M;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_led = 8'h01;
    m_cnt = '0;
    for (int c = 0; c < 2; c++) begin
      m_db[c]   = 1'b0;
      m_age[c]  = 0;
      m_hist[c] = '0;
    end
  endtask

  function automatic logic m_busy();
    return m_db[0] | m_db[1];
  endfunction

  // A tick happens on the first high cycle and at the repeat instants.
  function automatic logic chan_tick(int c);
    int a;
    a = m_age[c];
    return m_db[c] && (a == 0 || a == RD || (a > RD && (a - RD) % RP == 0));
  endfunction

  function automatic logic [W-1:0] step_led(logic [W-1:0] v, logic left, logic bar);
    if (left) return bar ? W'((v << 1) | 1) : W'((v << 1) | (v >> (W-1)));
    return bar ? W'(v >> 1) : W'((v >> 1) | (v << (W-1)));
  endfunction

  // Level flips once the DB most recent synchronised samples all disagree.
  task automatic chan_update(int c, logic b);
    logic [DB-1:0] win;
    m_hist[c] = {m_hist[c][DB:0], b};
    win = m_hist[c][DB+1:2];
    if (win == {DB{~m_db[c]}}) begin
      m_db[c]  = ~m_db[c];
      m_age[c] = 0;
    end else if (m_db[c]) begin
      m_age[c]++;
    end
  endtask

  task automatic model_step();
    logic tl, tr;
    logic [W-1:0] nxt;
    if (!RST_N) begin
      model_reset();
      return;
    end
    tl  = chan_tick(0);
    tr  = chan_tick(1);
    nxt = m_led;
    if (tl != tr) nxt = step_led(m_led, tl, MODE);
    if (nxt != m_led) begin
      m_cnt = m_cnt + 1'b1;
      exp_q.push_back(nxt);
    end
    m_led = nxt;
    chan_update(0, BTN_LEFT);
    chan_update(1, BTN_RIGHT);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick_clk();
    @(posedge CLK_100M);
    model_step();
    @(negedge CLK_100M);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    tick_clk();
    RST_N = 1'b1;
    tick_clk();
  endtask

  task automatic press(int c, int hold, int gap);
    if (c == 0) BTN_LEFT = 1'b1; else BTN_RIGHT = 1'b1;
    repeat (hold) tick_clk();
    if (c == 0) BTN_LEFT = 1'b0; else BTN_RIGHT = 1'b0;
    repeat (gap) tick_clk();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0; BTN_LEFT = 1'b0; BTN_RIGHT = 1'b0; MODE = 1'b0;
    model_reset();
    repeat (3) tick_clk();
    n_checks++;
    if (LED !== 8'h01 || STEP_CNT !== 16'd0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: LED=%h CNT=%0d BUSY=%b, required 01/0/0", LED, STEP_CNT, BUSY);
    end
    RST_N = 1'b1;
    repeat (2) tick_clk();
    n_checks++;
    if (LED !== m_led || STEP_CNT !== m_cnt || BUSY !== m_busy()) begin
      n_fail++;
      $display("FAIL reset_release: LED=%h/%h CNT=%0d/%0d BUSY=%b/%b", LED, m_led, STEP_CNT, m_cnt, BUSY, m_busy());
    end
  endtask

  task automatic test_clean_press();
    MODE = 1'b0;
    BTN_LEFT = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick_clk();
      n_checks++;
      if (LED !== m_led || STEP_CNT !== m_cnt || BUSY !== m_busy()) begin
        n_fail++;
        $display("FAIL clean_press k=%0d LED=%h/%h CNT=%0d/%0d BUSY=%b/%b", k, LED, m_led, STEP_CNT, m_cnt, BUSY, m_busy());
      end
      if (k == DB + 2 || k == DB + 3) begin
        n_checks++;
        if (LED !== ((k == DB + 3) ? 8'h02 : 8'h01)) begin
          n_fail++;
          $display("FAIL clean_press_latency k=%0d LED=%h required %h", k, LED, (k == DB + 3) ? 8'h02 : 8'h01);
        end
      end
    end
    BTN_LEFT = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick_clk();
      if (j == DB + 1 || j == DB + 2) begin
        n_checks++;
        if (BUSY !== (j == DB + 1)) begin
          n_fail++;
          $display("FAIL clean_press_busy j=%0d BUSY=%b required %b", j, BUSY, (j == DB + 1));
        end
      end
    end
    n_checks++;
    if (LED !== 8'h02 || STEP_CNT !== 16'd1) begin
      n_fail++;
      $display("FAIL clean_press_final LED=%h CNT=%0d required 02/1", LED, STEP_CNT);
    end
  endtask

  task automatic test_bounce();
    logic [CW-1:0] cnt0;
    logic          pat[5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    cnt0 = STEP_CNT;
    for (int i = 0; i < 29; i++) begin
      BTN_LEFT = (i < 5) ? pat[i] : (i < 17);
      tick_clk();
      n_checks++;
      if (LED !== m_led || STEP_CNT !== m_cnt || BUSY !== m_busy()) begin
        n_fail++;
        $display("FAIL bounce i=%0d LED=%h/%h CNT=%0d/%0d BUSY=%b/%b", i, LED, m_led, STEP_CNT, m_cnt, BUSY, m_busy());
      end
    end
    n_checks++;
    if (STEP_CNT !== cnt0 + 16'd1) begin
      n_fail++;
      $display("FAIL bounce_one_step CNT=%0d required %0d", STEP_CNT, cnt0 + 16'd1);
    end
    cnt0 = STEP_CNT;
    for (int g = 1; g <= 3; g++) begin
      for (int i = 0; i < g + 8; i++) begin
        BTN_RIGHT = (i < g);
        tick_clk();
        n_checks++;
        if (LED !== m_led || STEP_CNT !== m_cnt || BUSY !== m_busy()) begin
          n_fail++;
          $display("FAIL glitch g=%0d LED=%h/%h CNT=%0d/%0d BUSY=%b/%b", g, LED, m_led, STEP_CNT, m_cnt, BUSY, m_busy());
        end
      end
    end
    n_checks++;
    if (STEP_CNT !== cnt0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_no_step CNT=%0d BUSY=%b required %0d/0", STEP_CNT, BUSY, cnt0);
    end
  endtask

  task automatic test_modes();
    logic [W-1:0] exp_seq[4];
    exp_seq = '{8'h01, 8'h03, 8'h07, 8'hFF};
    do_reset();
    MODE = 1'b0;
    press(1, 8, 10);
    n_checks++;
    if (LED !== 8'h80 || STEP_CNT !== 16'd1) begin
      n_fail++;
      $display("FAIL rotate_right_wrap LED=%h CNT=%0d required 80/1", LED, STEP_CNT);
    end
    do_reset();
    MODE = 1'b1;
    press(1, 8, 10);
    for (int i = 0; i < 3; i++) begin
      press(0, 8, 10);
      n_checks++;
      if (LED !== exp_seq[i] || LED !== m_led) begin
        n_fail++;
        $display("FAIL bar_left i=%0d LED=%h required %h", i, LED, exp_seq[i]);
      end
    end
    repeat (3) press(1, 8, 10);
    press(1, 8, 10);
    n_checks++;
    if (LED !== 8'h00 || STEP_CNT !== 16'd7 || STEP_CNT !== m_cnt) begin
      n_fail++;
      $display("FAIL bar_right_saturate LED=%h CNT=%0d required 00/7", LED, STEP_CNT);
    end
    repeat (9) press(0, 8, 10);
    n_checks++;
    if (LED !== exp_seq[3] || STEP_CNT !== 16'd15) begin
      n_fail++;
      $display("FAIL bar_left_saturate LED=%h CNT=%0d required ff/15", LED, STEP_CNT);
    end
    MODE = 1'b0;
    press(0, 8, 10);
    n_checks++;
    if (LED !== 8'hFF || STEP_CNT !== 16'd15) begin
      n_fail++;
      $display("FAIL rotate_all_ones LED=%h CNT=%0d required ff/15", LED, STEP_CNT);
    end
  endtask

  task automatic test_repeat();
    do_reset();
    MODE = 1'b0;
    BTN_LEFT = 1'b1;
    for (int k = 0; k < 66; k++) begin
      if (k == 56) BTN_LEFT = 1'b0;
      tick_clk();
      n_checks++;
      if (LED !== m_led || STEP_CNT !== m_cnt || BUSY !== m_busy()) begin
        n_fail++;
        $display("FAIL repeat k=%0d LED=%h/%h CNT=%0d/%0d BUSY=%b/%b", k, LED, m_led, STEP_CNT, m_cnt, BUSY, m_busy());
      end
    end
    n_checks++;
    if (LED !== 8'h40 || STEP_CNT !== 16'd6) begin
      n_fail++;
      $display("FAIL repeat_total LED=%h CNT=%0d required 40/6", LED, STEP_CNT);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  led0;
    logic [CW-1:0] cnt0;
    MODE = 1'b0;
    led0 = LED;
    cnt0 = STEP_CNT;
    BTN_LEFT = 1'b1; BTN_RIGHT = 1'b1;
    repeat (8) tick_clk();
    BTN_LEFT = 1'b0; BTN_RIGHT = 1'b0;
    repeat (10) tick_clk();
    n_checks++;
    if (LED !== led0 || STEP_CNT !== cnt0) begin
      n_fail++;
      $display("FAIL both_cancel LED=%h CNT=%0d required %h/%0d", LED, STEP_CNT, led0, cnt0);
    end
    BTN_LEFT = 1'b1;
    tick_clk();
    BTN_RIGHT = 1'b1;
    repeat (8) tick_clk();
    BTN_LEFT = 1'b0;
    tick_clk();
    BTN_RIGHT = 1'b0;
    repeat (10) tick_clk();
    n_checks++;
    if (LED !== led0 || STEP_CNT !== cnt0 + 16'd2 || STEP_CNT !== m_cnt) begin
      n_fail++;
      $display("FAIL left_then_right LED=%h CNT=%0d required %h/%0d", LED, STEP_CNT, led0, cnt0 + 16'd2);
    end
  endtask

  task automatic test_reset_mid();
    MODE = 1'b0;
    BTN_LEFT = 1'b1;
    repeat (3) tick_clk();
    RST_N = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (LED !== 8'h01 || STEP_CNT !== 16'd0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_debounce LED=%h CNT=%0d BUSY=%b required 01/0/0", LED, STEP_CNT, BUSY);
    end
    @(negedge CLK_100M);
    RST_N = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick_clk();
      if (k == DB + 2 || k == DB + 3) begin
        n_checks++;
        if (LED !== ((k == DB + 3) ? 8'h02 : 8'h01)) begin
          n_fail++;
          $display("FAIL held_through_reset k=%0d LED=%h required %h", k, LED, (k == DB + 3) ? 8'h02 : 8'h01);
        end
      end
    end
    n_checks++;
    if (LED !== m_led || STEP_CNT !== m_cnt || STEP_CNT !== 16'd3) begin
      n_fail++;
      $display("FAIL before_mid_repeat LED=%h/%h CNT=%0d/%0d", LED, m_led, STEP_CNT, m_cnt);
    end
    RST_N = 1'b0;
    BTN_LEFT = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (LED !== 8'h01 || STEP_CNT !== 16'd0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_repeat LED=%h CNT=%0d BUSY=%b required 01/0/0", LED, STEP_CNT, BUSY);
    end
    @(negedge CLK_100M);
    RST_N = 1'b1;
    repeat (10) tick_clk();
    n_checks++;
    if (LED !== 8'h01 || STEP_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL after_reset_idle LED=%h CNT=%0d required 01/0", LED, STEP_CNT);
    end
  endtask

  task automatic test_random();
    int           hold_l, hold_r;
    logic [W-1:0] prev_led, exp_led;
    hold_l = 0;
    hold_r = 0;
    exp_q.delete();
    prev_led = LED;
    for (int i = 0; i < 1012; i++) begin
      if (i >= 1000) begin
        BTN_LEFT = 1'b0;
        BTN_RIGHT = 1'b0;
      end else begin
        if (hold_l == 0) begin
          BTN_LEFT = 1'($urandom_range(0, 1));
          hold_l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 34));
        end
        if (hold_r == 0) begin
          BTN_RIGHT = 1'($urandom_range(0, 1));
          hold_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 34));
        end
        hold_l--;
        hold_r--;
        if ($urandom_range(0, 40) == 0) MODE = ~MODE;
      end
      tick_clk();
      n_checks++;
      if (LED !== m_led || STEP_CNT !== m_cnt || BUSY !== m_busy()) begin
        n_fail++;
        $display("FAIL random i=%0d LED=%h/%h CNT=%0d/%0d BUSY=%b/%b", i, LED, m_led, STEP_CNT, m_cnt, BUSY, m_busy());
      end
      if (LED !== prev_led) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL random_scoreboard i=%0d LED=%h, required no change", i, LED);
        end else begin
          exp_led = exp_q.pop_front();
          if (LED !== exp_led) begin
            n_fail++;
            $display("FAIL random_scoreboard i=%0d LED=%h required %h", i, LED, exp_led);
          end
        end
        prev_led = LED;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_modes();
    test_repeat();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
